// File: rtl/logic_gate_pipe.sv
// Bitwise logic unit (AND/NAND/OR/NOR/XOR/XNOR/NOT/PASS) with a DEPTH-entry
// result FIFO and a valid/ready handshake on both sides.

module logic_gate_lane (
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    output logic       y
);
    always_comb begin
        y = 1'b0;
        case (op)
            3'd0: y = a & b;
            3'd1: y = ~(a & b);
            3'd2: y = a | b;
            3'd3: y = ~(a | b);
            3'd4: y = a ^ b;
            3'd5: y = ~(a ^ b);
            3'd6: y = ~a;
            3'd7: y = a;
            default: y = 1'b0;
        endcase
    end
endmodule

module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all1,
    output logic             y_zero
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             all1;
        logic             zero;
    } res_t;

    logic [WIDTH-1:0] y_new;
    res_t             new_res;
    res_t             mem [DEPTH];
    res_t             head_q;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [CNT_W-1:0] count;
    logic             accept, consume;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic_gate_lane u_lane (.a(a[i]), .b(b[i]), .op(op), .y(y_new[i]));
    end

    assign new_res   = '{y: y_new, all1: &y_new, zero: ~|y_new};
    assign in_ready  = (count != CNT_FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign rd_nxt    = rd_ptr + PTR_W'(1);

    assign y      = head_q.y;
    assign y_all1 = head_q.all1;
    assign y_zero = head_q.zero;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= new_res;
    end

    // head_q mirrors mem[rd_ptr] one cycle early so outputs have a defined
    // reset value without resetting the storage array; when the next head is
    // the entry being written this edge, it is taken straight from new_res.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            head_q <= '{y: '0, all1: 1'b0, zero: 1'b1};
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (consume) rd_ptr <= rd_nxt;
            case ({accept, consume})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (consume) begin
                if (count == CNT_ONE) begin
                    if (accept) head_q <= new_res;
                end else begin
                    head_q <= mem[rd_nxt];
                end
            end else if (count == '0 && accept) begin
                head_q <= new_res;
            end
        end
    end
endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: truth tables, 8-bit vectors,
// backpressure, streaming, async reset and pointer wrap.

module tb_logic_gate_pipe;
    logic clk, rst;
    int   checks, failures;

    // WIDTH=1, DEPTH=2
    logic       d1_iv, d1_ir, d1_ov, d1_or, d1_all1, d1_zero;
    logic [0:0] d1_a, d1_b, d1_y;
    logic [2:0] d1_op;
    // WIDTH=8, DEPTH=2
    logic       d2_iv, d2_ir, d2_ov, d2_or, d2_all1, d2_zero;
    logic [7:0] d2_a, d2_b, d2_y;
    logic [2:0] d2_op;
    // WIDTH=8, DEPTH=4
    logic       d4_iv, d4_ir, d4_ov, d4_or, d4_all1, d4_zero;
    logic [7:0] d4_a, d4_b, d4_y;
    logic [2:0] d4_op;

    logic_gate_pipe #(.WIDTH(1), .DEPTH(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(d1_iv), .in_ready(d1_ir), .a(d1_a), .b(d1_b),
        .op(d1_op), .out_valid(d1_ov), .out_ready(d1_or), .y(d1_y), .y_all1(d1_all1),
        .y_zero(d1_zero));
    logic_gate_pipe #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(d2_iv), .in_ready(d2_ir), .a(d2_a), .b(d2_b),
        .op(d2_op), .out_valid(d2_ov), .out_ready(d2_or), .y(d2_y), .y_all1(d2_all1),
        .y_zero(d2_zero));
    logic_gate_pipe #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(d4_iv), .in_ready(d4_ir), .a(d4_a), .b(d4_b),
        .op(d4_op), .out_valid(d4_ov), .out_ready(d4_or), .y(d4_y), .y_all1(d4_all1),
        .y_zero(d4_zero));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit {a,b} of each entry is the 1-bit result for that operand pair.
    logic [3:0] tt_tab [8] = '{4'b1000, 4'b0111, 4'b1110, 4'b0001,
                               4'b0110, 4'b1001, 4'b0011, 4'b1100};

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return ~(x & z);
            3'd2: return x | z;
            3'd3: return ~(x | z);
            3'd4: return x ^ z;
            3'd5: return ~(x ^ z);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) edge_step();
        checks++;
        if ({d1_ov, d1_ir, d1_y, d1_all1, d1_zero} !== 5'b01001) begin
            failures++;
            $display("FAIL reset_w1 got ov/ir/y/all1/zero=%b exp=01001", {d1_ov, d1_ir, d1_y, d1_all1, d1_zero});
        end
        checks++;
        if ({d2_ov, d2_ir, d2_y, d2_all1, d2_zero} !== 12'b01_00000000_01) begin
            failures++;
            $display("FAIL reset_d2 got %b exp 010000000001", {d2_ov, d2_ir, d2_y, d2_all1, d2_zero});
        end
        checks++;
        if ({d4_ov, d4_ir, d4_y, d4_all1, d4_zero} !== 12'b01_00000000_01) begin
            failures++;
            $display("FAIL reset_d4 got %b exp 010000000001", {d4_ov, d4_ir, d4_y, d4_all1, d4_zero});
        end
        #3 rst = 1'b0;
        edge_step();
    endtask

    task automatic test_truth_table();
        logic [1:0] abv;
        logic [3:0] tt;
        logic       e;
        d1_or = 1'b1;
        for (int o = 0; o < 8; o++) begin
            for (int ab = 0; ab < 4; ab++) begin
                abv   = 2'(ab);
                tt    = tt_tab[o];
                e     = tt[abv];
                d1_a  = abv[1];
                d1_b  = abv[0];
                d1_op = 3'(o);
                d1_iv = 1'b1;
                checks++;
                if (d1_ir !== 1'b1) begin
                    failures++;
                    $display("FAIL tt_in_ready op=%0d ab=%0d got=%b exp=1", o, ab, d1_ir);
                end
                edge_step();
                d1_iv = 1'b0;
                checks++;
                if ({d1_ov, d1_y, d1_all1, d1_zero} !== {1'b1, e, e, ~e}) begin
                    failures++;
                    $display("FAIL tt op=%0d ab=%0d got ov/y/all1/zero=%b exp=%b", o, ab,
                             {d1_ov, d1_y, d1_all1, d1_zero}, {1'b1, e, e, ~e});
                end
                edge_step();
                checks++;
                if (d1_ov !== 1'b0) begin
                    failures++;
                    $display("FAIL tt_drain op=%0d ab=%0d out_valid got=%b exp=0", o, ab, d1_ov);
                end
            end
        end
        d1_or = 1'b0;
    endtask

    task automatic test_vectors_w8();
        logic [7:0] va [5] = '{8'hF0, 8'hF0, 8'hAA, 8'hFF, 8'hFF};
        logic [7:0] vb [5] = '{8'hFF, 8'hFF, 8'h55, 8'h00, 8'h00};
        logic [2:0] vo [5] = '{3'd4, 3'd5, 3'd0, 3'd7, 3'd6};
        logic [7:0] vy [5] = '{8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00};
        logic       v1 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       vz [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        d2_or = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d2_a = va[i]; d2_b = vb[i]; d2_op = vo[i]; d2_iv = 1'b1;
            edge_step();
            d2_iv = 1'b0;
            checks++;
            if ({d2_ov, d2_y, d2_all1, d2_zero} !== {1'b1, vy[i], v1[i], vz[i]}) begin
                failures++;
                $display("FAIL vec%0d got ov=%b y=%h all1=%b zero=%b exp ov=1 y=%h all1=%b zero=%b",
                         i, d2_ov, d2_y, d2_all1, d2_zero, vy[i], v1[i], vz[i]);
            end
            edge_step();
        end
        d2_or = 1'b0;
    endtask

    task automatic test_backpressure();
        d2_or = 1'b0;
        d2_a = 8'h0C; d2_b = 8'h30; d2_op = 3'd2; d2_iv = 1'b1;   // -> 3C
        edge_step();
        checks++;
        if ({d2_ov, d2_ir, d2_y} !== {2'b11, 8'h3C}) begin
            failures++;
            $display("FAIL bp_first got ov=%b ir=%b y=%h exp ov=1 ir=1 y=3c", d2_ov, d2_ir, d2_y);
        end
        d2_a = 8'h0F; d2_b = 8'hF0; d2_op = 3'd3;                  // -> 00
        edge_step();
        checks++;
        if ({d2_ov, d2_ir, d2_y} !== {2'b10, 8'h3C}) begin
            failures++;
            $display("FAIL bp_full got ov=%b ir=%b y=%h exp ov=1 ir=0 y=3c", d2_ov, d2_ir, d2_y);
        end
        d2_a = 8'h5A; d2_b = 8'h00; d2_op = 3'd6;                  // -> A5, held off
        edge_step();
        checks++;
        if ({d2_ov, d2_ir, d2_y} !== {2'b10, 8'h3C}) begin
            failures++;
            $display("FAIL bp_stall got ov=%b ir=%b y=%h exp ov=1 ir=0 y=3c", d2_ov, d2_ir, d2_y);
        end
        d2_or = 1'b1;
        edge_step();
        checks++;
        if ({d2_ov, d2_ir, d2_y, d2_zero} !== {2'b11, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL bp_drain1 got ov=%b ir=%b y=%h zero=%b exp ov=1 ir=1 y=00 zero=1", d2_ov, d2_ir, d2_y, d2_zero);
        end
        edge_step();
        d2_iv = 1'b0;
        checks++;
        if ({d2_ov, d2_y} !== {1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL bp_third got ov=%b y=%h exp ov=1 y=a5", d2_ov, d2_y);
        end
        edge_step();
        checks++;
        if ({d2_ov, d2_ir} !== 2'b01) begin
            failures++;
            $display("FAIL bp_empty got ov=%b ir=%b exp ov=0 ir=1", d2_ov, d2_ir);
        end
        d2_or = 1'b0;
    endtask

    task automatic test_streaming();
        logic [7:0] q [$];
        logic [7:0] e;
        int         bad;
        bad = 0;
        d4_or = 1'b1;
        d4_iv = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d4_a  = 8'($urandom);
            d4_b  = 8'($urandom);
            d4_op = 3'($urandom_range(7));
            q.push_back(ref_op(d4_op, d4_a, d4_b));
            edge_step();
            e = q.pop_front();
            checks++;
            if ({d4_ov, d4_ir, d4_y} !== {2'b11, e}) begin
                failures++;
                $display("FAIL stream%0d got ov=%b ir=%b y=%h exp ov=1 ir=1 y=%h", i, d4_ov, d4_ir, d4_y, e);
            end
        end
        d4_iv = 1'b0;
        edge_step();
        checks++;
        if (d4_ov !== 1'b0) begin
            failures++;
            $display("FAIL stream_end out_valid got=%b exp=0", d4_ov);
        end
        d4_or = 1'b0;
    endtask

    task automatic test_async_reset();
        d2_or = 1'b0;
        d2_a = 8'hFF; d2_b = 8'h3C; d2_op = 3'd0; d2_iv = 1'b1;
        edge_step();
        d2_a = 8'hFF; d2_b = 8'h01; d2_op = 3'd4;
        edge_step();
        d2_iv = 1'b0;
        checks++;
        if ({d2_ov, d2_ir, d2_y} !== {2'b10, 8'h3C}) begin
            failures++;
            $display("FAIL ar_pre got ov=%b ir=%b y=%h exp ov=1 ir=0 y=3c", d2_ov, d2_ir, d2_y);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({d2_ov, d2_ir, d2_y, d2_all1, d2_zero} !== {2'b01, 8'h00, 2'b01}) begin
            failures++;
            $display("FAIL ar_during got ov=%b ir=%b y=%h all1=%b zero=%b exp 0 1 00 0 1",
                     d2_ov, d2_ir, d2_y, d2_all1, d2_zero);
        end
        #1 rst = 1'b0;
        d2_a = 8'h81; d2_b = 8'h00; d2_op = 3'd7; d2_iv = 1'b1;
        edge_step();
        d2_iv = 1'b0;
        checks++;
        if ({d2_ov, d2_y} !== {1'b1, 8'h81}) begin
            failures++;
            $display("FAIL ar_first got ov=%b y=%h exp ov=1 y=81", d2_ov, d2_y);
        end
        d2_or = 1'b1;
        edge_step();
        checks++;
        if (d2_ov !== 1'b0) begin
            failures++;
            $display("FAIL ar_stale out_valid got=%b exp=0", d2_ov);
        end
        d2_or = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] wa [7] = '{8'hF0, 8'hF0, 8'h81, 8'h81, 8'hFF, 8'hA5, 8'h00};
        logic [7:0] wb [7] = '{8'h3C, 8'h3C, 8'h18, 8'h18, 8'h0F, 8'h5A, 8'h12};
        logic [7:0] wy [7] = '{8'h30, 8'hCF, 8'h99, 8'h66, 8'hF0, 8'h00, 8'hFF};
        logic       w1 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       wz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            d2_or = 1'b0;
            d2_a = wa[i]; d2_b = wb[i]; d2_op = 3'(i); d2_iv = 1'b1;
            edge_step();
            d2_iv = 1'b0;
            checks++;
            if ({d2_ov, d2_y, d2_all1, d2_zero} !== {1'b1, wy[i], w1[i], wz[i]}) begin
                failures++;
                $display("FAIL wrap%0d got ov=%b y=%h all1=%b zero=%b exp ov=1 y=%h all1=%b zero=%b",
                         i, d2_ov, d2_y, d2_all1, d2_zero, wy[i], w1[i], wz[i]);
            end
            d2_or = 1'b1;
            edge_step();
            checks++;
            if ({d2_ov, d2_ir} !== 2'b01) begin
                failures++;
                $display("FAIL wrap%0d_drain got ov=%b ir=%b exp ov=0 ir=1", i, d2_ov, d2_ir);
            end
        end
        d2_or = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        d1_iv = 0; d1_or = 0; d1_a = '0; d1_b = '0; d1_op = '0;
        d2_iv = 0; d2_or = 0; d2_a = '0; d2_b = '0; d2_op = '0;
        d4_iv = 0; d4_or = 0; d4_a = '0; d4_b = '0; d4_op = '0;
        test_reset();
        test_truth_table();
        test_vectors_w8();
        test_backpressure();
        test_streaming();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
